seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexing scan controller that shares one BCD-to-7-segment decoder across NUM_DIG digits.
//  Double-buffers a packed BCD word loaded through a valid/ready handshake and swaps it in only at frame boundaries.
//  Steps through the digits at a divided rate, with a one-cycle anti-ghosting guard between digits.
//  Drives the decoder input (bcd_out), the one-hot digit enables and the blank/dp controls.
// PARAMETERS
//  NUM_DIG  4      number of multiplexed digits (2..8)
//  DIV_W    16     divider counter width
//  DIV_MAX  49999  divider terminal count; dwell per digit = DIV_MAX+1 cycles
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          synchronous, active-high reset
//  load_valid  in   1          new display word offered
//  load_ready  out  1          pending buffer empty; load accepted when load_valid&load_ready
//  load_data   in   4*NUM_DIG  packed BCD; digit i = [4i+3:4i], digit 0 = rightmost
//  load_dp     in   NUM_DIG    decimal-point mask, captured with load_data
//  bcd_out     out  4          BCD nibble fed to the shared decoder
//  dig_sel     out  NUM_DIG    one-hot digit enable, active-high; all-zero during guard/reset
//  blank       out  1          1 = decoder output must be forced dark
//  dp          out  1          decimal point for the selected digit
//  frame_done  out  1          1-cycle pulse on entry to digit 0 (new frame)
// BEHAVIOUR
//  Reset: dig_sel=0, bcd_out=0, blank=1, dp=0, frame_done=0, load_ready=1, idx=0, div_cnt=0.
//   Active buffer = all 4'hF (blanked); pending buffer empty. Reset mid-scan or mid-handshake drops pending data.
//  Divider: div_cnt runs 0..DIV_MAX and wraps; tick = (div_cnt==DIV_MAX). Runs continuously in SHOW, cleared in GUARD.
//  FSM (registered outputs):
//   RST_WAIT: first cycle after reset -> SHOW, idx=0, frame_done=1.
//   SHOW: dig_sel[idx]=1; bcd_out=act[idx]; dp=act_dp[idx]; on tick -> GUARD.
//   GUARD: exactly 1 cycle; dig_sel=0, blank=1; idx <= (idx==NUM_DIG-1)?0:idx+1; -> SHOW.
//  Frame swap: on the GUARD cycle with idx==NUM_DIG-1, if pending_vld (value at start of cycle):
//   act<=pending and pending_vld<=0. frame_done pulses on the following SHOW(idx=0) cycle.
//  Handshake: load_ready = ~pending_vld. A load accepted in the same cycle as a swap stays pending
//   for the next frame. load_data and load_dp are sampled only on accept; load_valid while not ready is held off.
//  Latency: accepted word is displayed from the first digit-0 SHOW after the next frame swap.
//  Invalid BCD: nibble > 9 -> blank=1, bcd_out=4'h0. The decoder holds its last value for out-of-range input,
//   so the controller must blank instead.
//  Output timing: dig_sel, bcd_out, blank and dp change together on the same edge. No cycle has two digits enabled.
// CONFIGURATION
//  SEG_ZERO_BLANK_EN defined: leading zeros are blanked. Digit i>0 is blanked if it and every digit above it are 0.
//   Digit 0 is always shown. dp=1 on a digit keeps that digit and all lower digits unblanked.
//  Undefined: every in-range digit, including 0, is shown.
// STRUCTURE
//  Package seg_pkg: state enum {RST_WAIT,SHOW,GUARD}; BLANK_CODE=4'hF; BCD_MAX=4'd9.
//  One sub-module seg_scan_div: parameterised DIV_W/DIV_MAX counter with clr input and tick output.
//  FSM, buffers and output muxing stay in seg_scan_ctrl.
// TESTING (NUM_DIG=4, DIV_MAX=3)
//  Reset, no load -> dig_sel 0001,0000,0010,0000,0100,...; blank=1 on every cycle; each digit dwells 4 cycles.
//  Load 16'h1234 and dp 4'b0100 in idle -> load_ready=0 until the swap; next frame shows bcd 4,3,2,1;
//   dp=1 only while dig_sel=0100.
//  Second load offered while pending is full -> held off until the swap; then accepted and shown one frame later.
//  Load 16'h00A5 -> digit1 (value A) blank=1, bcd_out=0; digit0 shows 5.
//   Digits 3/2 show 0 without SEG_ZERO_BLANK_EN and are blanked with it.
//  Assert rst during SHOW of digit 2 with a pending word -> next cycle outputs reset values;
//   pending dropped; display all blank.
//  Continuous: assert $onehot0(dig_sel) every cycle; frame_done period = 4*(4+1)=20 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: FSM state codes and BCD limits.
package seg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RST_WAIT = 2'd0;
  localparam state_t SHOW     = 2'd1;
  localparam state_t GUARD    = 2'd2;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // The shared decoder latches on out-of-range input, so these nibbles must be blanked.
  function automatic logic bcd_bad(input logic [3:0] n);
    return n > BCD_MAX;
  endfunction

endpackage

// File: rtl/seg_scan_div.sv
// Digit dwell divider: counts 0..DIV_MAX while enabled, pulses tick on the terminal count.
module seg_scan_div #(
  parameter int          DIV_W   = 16,
  parameter int unsigned DIV_MAX = 49999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = ~clr && (cnt == DIV_W'(DIV_MAX));

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIG digits sharing one BCD-to-7-segment decoder.
// Define SEG_ZERO_BLANK_EN to blank leading zeros (digit 0 and dp-marked digits stay lit).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int          NUM_DIG = 4,
  parameter int          DIV_W   = 16,
  parameter int unsigned DIV_MAX = 49999
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NUM_DIG-1:0]   load_data,
  input  logic [NUM_DIG-1:0]     load_dp,
  output logic [3:0]             bcd_out,
  output logic [NUM_DIG-1:0]     dig_sel,
  output logic                   blank,
  output logic                   dp,
  output logic                   frame_done
);

  localparam int IW = $clog2(NUM_DIG);

  state_t                      state, state_n;
  logic [IW-1:0]               idx, idx_n;
  logic [NUM_DIG-1:0][3:0]     act, pend, act_n;
  logic [NUM_DIG-1:0]          act_dp, pend_dp, act_dp_n;
  logic                        pend_vld;
  logic                        tick, last, swap, accept;
  logic [NUM_DIG-1:0][3:0]     dbcd;
  logic [NUM_DIG-1:0]          dblank;

  seg_scan_div #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != SHOW),
    .tick (tick)
  );

  assign last       = (idx == IW'(NUM_DIG-1));
  assign swap       = (state == GUARD) && last && pend_vld;
  assign accept     = load_valid && !pend_vld;
  assign load_ready = ~pend_vld;
  assign act_n      = swap ? pend    : act;
  assign act_dp_n   = swap ? pend_dp : act_dp;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      RST_WAIT: begin state_n = SHOW; idx_n = '0; end
      SHOW:     if (tick) state_n = GUARD;
      GUARD:    begin state_n = SHOW; idx_n = last ? '0 : idx + 1'b1; end
      default:  begin state_n = RST_WAIT; idx_n = '0; end
    endcase
  end

`ifdef SEG_ZERO_BLANK_EN
  // lz[i]: digit i and everything above it are zero with no decimal point set.
  logic [NUM_DIG-1:0] lz;
`endif

  // Per-digit decode is computed from the post-swap buffer so a new frame starts clean.
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    logic zb;
`ifdef SEG_ZERO_BLANK_EN
    if (i == NUM_DIG-1) begin : g_top
      assign lz[i] = (act_n[i] == 4'd0) && !act_dp_n[i];
    end else begin : g_low
      assign lz[i] = (act_n[i] == 4'd0) && !act_dp_n[i] && lz[i+1];
    end
    assign zb = (i > 0) && lz[i];
`else
    assign zb = 1'b0;
`endif
    assign dblank[i] = bcd_bad(act_n[i]) || zb;
    assign dbcd[i]   = bcd_bad(act_n[i]) ? 4'h0 : act_n[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_WAIT;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act      <= {NUM_DIG{BLANK_CODE}};
      act_dp   <= '0;
      pend     <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
    end else begin
      act    <= act_n;
      act_dp <= act_dp_n;
      if (swap) pend_vld <= 1'b0;
      if (accept) begin
        pend     <= load_data;
        pend_dp  <= load_dp;
        pend_vld <= 1'b1;
      end
    end
  end

  // Outputs are registered from next-state values so all controls move on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_sel    <= '0;
      bcd_out    <= 4'h0;
      blank      <= 1'b1;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state_n == SHOW) && (idx_n == '0) && (state != SHOW);
      if (state_n == SHOW) begin
        dig_sel <= {{(NUM_DIG-1){1'b0}}, 1'b1} << idx_n;
        bcd_out <= dbcd[idx_n];
        blank   <= dblank[idx_n];
        dp      <= act_dp_n[idx_n];
      end else begin
        dig_sel <= '0;
        bcd_out <= 4'h0;
        blank   <= 1'b1;
        dp      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position reference model plus table-driven display vectors.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DM    = 3;
  localparam int DWELL = DM + 2;
  localparam int FRAME = ND * DWELL;
`ifdef SEG_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_sel;
  logic        blank, dp, frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIG(ND), .DIV_W(4), .DIV_MAX(DM)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dp(load_dp), .bcd_out(bcd_out), .dig_sel(dig_sel),
    .blank(blank), .dp(dp), .frame_done(frame_done)
  );

  int tests = 0, fails = 0, cyc = 0;

  // Model: k = cycles since the first digit-0 display (-1 while in reset / first cycle after).
  bit m_known = 1'b0;
  int k = -1;
  int m_act[ND], m_adp[ND], m_pend[ND], m_pdp[ND];
  bit m_pv;

  logic [15:0] obs_bcd;
  logic [3:0]  obs_blank, obs_dp;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dpm;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit e_blank(int d);
    bit z;
    if (m_act[d] > 9) return 1'b1;
    if (!ZB || d == 0) return 1'b0;
    z = 1'b1;
    for (int j = d; j < ND; j++) if (m_act[j] != 0 || m_adp[j] != 0) z = 1'b0;
    return z;
  endfunction

  task automatic step();
    bit acc, swp;
    int p, d;
    bit g;
    acc = !rst && load_valid && !m_pv;
    swp = !rst && m_known && k >= 0 && (k % FRAME) == FRAME-1 && m_pv;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst) begin
      m_known = 1'b1; k = -1; m_pv = 1'b0;
      for (int j = 0; j < ND; j++) begin m_act[j] = 15; m_adp[j] = 0; end
    end else if (m_known) begin
      if (swp) begin
        for (int j = 0; j < ND; j++) begin m_act[j] = m_pend[j]; m_adp[j] = m_pdp[j]; end
        m_pv = 1'b0;
      end
      if (acc) begin
        for (int j = 0; j < ND; j++) begin m_pend[j] = int'(load_data[4*j +: 4]); m_pdp[j] = int'(load_dp[j]); end
        m_pv = 1'b1;
      end
      k++;
    end
    for (int j = 0; j < ND; j++)
      if (dig_sel == 4'(1 << j)) begin
        obs_bcd[4*j +: 4] = bcd_out; obs_blank[j] = blank; obs_dp[j] = dp;
      end
    if (!m_known) return;
    chk("onehot0", 32'($onehot0(dig_sel)), 1);
    chk("load_ready", load_ready, !m_pv);
    if (k < 0) begin
      chk("rst_sel", dig_sel, 0);
      chk("rst_blank", blank, 1);
      chk("rst_bcd", bcd_out, 0);
      chk("rst_dp", dp, 0);
      chk("rst_fd", frame_done, 0);
    end else begin
      p = k % FRAME; d = p / DWELL; g = (p % DWELL) == DWELL-1;
      chk("dig_sel", dig_sel, g ? 0 : (1 << d));
      chk("frame_done", frame_done, p == 0);
      if (g) chk("guard_blank", blank, 1);
      else begin
        chk("blank", blank, e_blank(d));
        chk("bcd", bcd_out, m_act[d] > 9 ? 0 : m_act[d]);
        chk("dp", dp, m_adp[d]);
      end
    end
  endtask

  task automatic load(input logic [15:0] data, input logic [3:0] dpm);
    bit ok = 1'b0;
    load_valid = 1'b1; load_data = data; load_dp = dpm;
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = load_ready;
      step();
    end
    load_valid = 1'b0;
    chk("load_accepted", ok, 1);
  endtask

  // Wait for the swap (pending drains), then capture the whole frame it starts.
  task automatic capture_after_swap();
    int n = 0;
    obs_bcd = 'x; obs_blank = 'x; obs_dp = 'x;
    do begin step(); n++; end while (!load_ready && n < 100);
    chk("swap_seen", load_ready, 1);
    chk("swap_fd", frame_done, 1);
    repeat (FRAME-1) step();
  endtask

  task automatic cmp_frame(input string tag, input logic [15:0] b, input logic [3:0] bl, input logic [3:0] d);
    chk({tag, "_bcd"}, obs_bcd, b);
    chk({tag, "_blank"}, obs_blank, bl);
    chk({tag, "_dp"}, obs_dp, d);
  endtask

  initial begin
    logic [3:0] exp_sel[10];
    int fd_cyc[$];
    int held;
    bit ok;

    tbl[0] = '{16'h1234, 4'b0100, 16'h1234, 4'b0000, 4'b0100};
    tbl[1] = '{16'h00A5, 4'b0000, 16'h0005, ZB ? 4'b1110 : 4'b0010, 4'b0000};
    tbl[2] = '{16'h0000, 4'b0000, 16'h0000, ZB ? 4'b1110 : 4'b0000, 4'b0000};
    tbl[3] = '{16'h0F09, 4'b0001, 16'h0009, ZB ? 4'b1100 : 4'b0100, 4'b0001};
    tbl[4] = '{16'h0070, 4'b1000, 16'h0070, 4'b0000, 4'b1000};
    tbl[5] = '{16'h9876, 4'b1111, 16'h9876, 4'b0000, 4'b1111};
    tbl[6] = '{16'h00B0, 4'b0010, 16'h0000, ZB ? 4'b1110 : 4'b0010, 4'b0010};
    exp_sel = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};

    // Reset with no load: blank scan, 4-cycle dwell, 20-cycle frame.
    rst = 1'b1;
    step(); step();
    chk("reset_ready", load_ready, 1);
    chk("reset_sel", dig_sel, 0);
    chk("reset_blank", blank, 1);
    rst = 1'b0;
    for (int i = 0; i < 2*FRAME+1; i++) begin
      step();
      if (i < 10) begin
        chk("idle_seq_sel", dig_sel, exp_sel[i]);
        chk("idle_seq_blank", blank, 1);
      end
      if (frame_done) fd_cyc.push_back(cyc);
    end
    chk("fd_count", fd_cyc.size(), 3);
    if (fd_cyc.size() >= 2) chk("fd_period", fd_cyc[1] - fd_cyc[0], FRAME);

    // Table-driven display words.
    for (int t = 0; t < 7; t++) begin
      load(tbl[t].data, tbl[t].dpm);
      capture_after_swap();
      cmp_frame($sformatf("tbl%0d", t), tbl[t].bcd, tbl[t].blank, tbl[t].dp);
    end

    // Second load offered while pending is full is held off until the swap.
    load(16'h4321, 4'b0000);
    load_valid = 1'b1; load_data = 16'h0506; load_dp = 4'b0010;
    obs_bcd = 'x; obs_blank = 'x; obs_dp = 'x;
    held = 0;
    do begin step(); held++; end while (!load_ready && held < 100);
    chk("held_off", held > 1, 1);
    chk("held_swap_fd", frame_done, 1);
    step();
    load_valid = 1'b0;
    chk("held_accepted", load_ready, 0);
    repeat (FRAME-2) step();
    cmp_frame("held_first", 16'h4321, 4'b0000, 4'b0000);
    capture_after_swap();
    cmp_frame("held_second", 16'h0506, ZB ? 4'b1000 : 4'b0000, 4'b0010);

    // Reset during digit 2 with a word pending.
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin step(); ok = frame_done; end
    load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'b1010;
    step();
    load_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin step(); ok = (dig_sel == 4'b0100); end
    chk("mid_pending", load_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sel", dig_sel, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_blank", blank, 1);
    obs_blank = 'x;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin step(); ok = frame_done; end
    repeat (FRAME-1) step();
    chk("mid_rst_all_blank", obs_blank, 4'b1111);

    // Randomized traffic including occasional resets.
    for (int i = 0; i < 1500; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      load_dp    = 4'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
